// File: rtl/norm_pipe_pkg.sv
// Shared parameters and types for the normalization pipeline.
// Default widths live here so every block built on them agrees on format.
package norm_pipe_pkg;

    localparam int SIG_WIDTH_DEF = 23;
    localparam int EXP_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        KIND_NORM,
        KIND_UNDER,
        KIND_RSHIFT,
        KIND_OVF,
        KIND_ZERO
    } norm_kind_e;

endpackage

// File: rtl/norm_pipe_lzc.sv
// Parametrised leading-zero counter: count of zeros above the most significant set bit.
// count is meaningless when all_zero is set; it is then driven to 0.
module lzc #(
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        count    = '0;
        all_zero = (vec == '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_pipe.sv
// Two-stage floating-point sum normalizer with valid/ready flow control.
// S1 captures the sum and its leading-zero count; S2 shifts and adjusts the exponent.
module norm_pipe
    import norm_pipe_pkg::*;
#(
    parameter int SIG_WIDTH = SIG_WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    localparam int W  = 2 * SIG_WIDTH + 3,
    localparam int CW = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         sum_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         mant_o,
    output logic [EXP_WIDTH-1:0] exp_o,
    output logic [CW-1:0]        amt_o,
    output logic                 rshift_o,
    output logic                 zero_o,
    output logic                 uf_o,
    output logic                 of_o
);

    localparam int XW = EXP_WIDTH + 1;
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};

    logic                 s1_valid;
    logic [W-1:0]         s1_sum;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [CW-1:0]        s1_lz;
    logic                 s1_low_zero;

    logic [CW-1:0]        lz_in;
    logic                 low_zero_in;
    logic                 s2_ready;

    norm_kind_e           kind;
    logic [W-1:0]         n_mant;
    logic [EXP_WIDTH-1:0] n_exp;
    logic [CW-1:0]        n_amt;
    logic [XW-1:0]        exp_x;
    logic [XW-1:0]        exp_inc;
    logic [XW-1:0]        lz_x;

    lzc #(
        .WIDTH (W - 1),
        .CNT_W (CW)
    ) u_lzc (
        .vec      (sum_i[W-2:0]),
        .count    (lz_in),
        .all_zero (low_zero_in)
    );

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sum      <= '0;
            s1_exp      <= '0;
            s1_lz       <= '0;
            s1_low_zero <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum      <= sum_i;
                s1_exp      <= exp_i;
                s1_lz       <= lz_in;
                s1_low_zero <= low_zero_in;
            end
        end
    end

    // Classify first, then build the result; exponent math is one bit wider so overflow is visible.
    always_comb begin
        kind    = KIND_NORM;
        n_mant  = '0;
        n_exp   = '0;
        n_amt   = '0;
        exp_x   = {1'b0, s1_exp};
        exp_inc = exp_x + XW'(1);
        lz_x    = XW'(s1_lz);

        if (s1_sum[W-1]) begin
            kind = (exp_inc >= EXP_MAX) ? KIND_OVF : KIND_RSHIFT;
        end else if (s1_low_zero) begin
            kind = KIND_ZERO;
        end else if (lz_x < exp_x) begin
            kind = KIND_NORM;
        end else begin
            kind = KIND_UNDER;
        end

        case (kind)
            KIND_RSHIFT: begin
                n_amt  = CW'(1);
                n_mant = {1'b0, s1_sum[W-1:2], s1_sum[1] | s1_sum[0]};
                n_exp  = exp_inc[EXP_WIDTH-1:0];
            end
            KIND_OVF: begin
                n_amt = CW'(1);
                n_exp = '1;
            end
            KIND_NORM: begin
                n_amt  = s1_lz;
                n_mant = s1_sum << s1_lz;
                n_exp  = EXP_WIDTH'(exp_x - lz_x);
            end
            KIND_UNDER: begin
                n_amt  = (s1_exp == '0) ? '0 : CW'(exp_x - XW'(1));
                n_mant = s1_sum << n_amt;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            mant_o    <= '0;
            exp_o     <= '0;
            amt_o     <= '0;
            rshift_o  <= 1'b0;
            zero_o    <= 1'b0;
            uf_o      <= 1'b0;
            of_o      <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                mant_o   <= n_mant;
                exp_o    <= n_exp;
                amt_o    <= n_amt;
                rshift_o <= (kind == KIND_RSHIFT) || (kind == KIND_OVF);
                zero_o   <= (kind == KIND_ZERO);
                uf_o     <= (kind == KIND_UNDER);
                of_o     <= (kind == KIND_OVF);
            end
        end
    end

endmodule

// File: doc/norm_pipe.md
NORM_PIPE -- requirements
Module: norm_pipe

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 23, significand fraction width; W = 2*SIG_WIDTH+3 is the sum width.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, biased exponent width; CW = $clog2(W) is the shift-count width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  sum_i/exp_i valid.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 sum_i  input  W  unnormalized sum; bit W-1 is the carry-out position.
REQ-008 exp_i  input  EXP_WIDTH  biased exponent paired with sum_i.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 mant_o  output  W  normalized sum; leading one at bit W-2 unless denormal or zero.
REQ-012 exp_o  output  EXP_WIDTH  adjusted exponent.
REQ-013 amt_o  output  CW  applied shift magnitude.
REQ-014 rshift_o, zero_o, uf_o, of_o  output  1 each  right-shift taken, zero sum, underflow/denormal, exponent overflow.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers sum, exp and leading-zero count lz of sum_i[W-2:0]; S2 registers shifted mantissa, exponent and flags.
REQ-016 Latency SHALL be 2 cycles from accepted input to out_valid; throughput one result per cycle when out_ready=1.
REQ-017 Transfer on in_valid&&in_ready, resp. out_valid&&out_ready; each stage advances when empty or next stage advances; in_ready = !S1_valid || S1 advances.
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable; no result dropped or duplicated; order preserved.
REQ-019 sum[W-1]=1: rshift_o=1, amt_o=1, mant_o = sum>>1 with bit 0 = sum[1]|sum[0] (sticky), exp_o = exp_i+1.
REQ-020 Right shift with exp_i+1 >= 2^EXP_WIDTH-1: exp_o = all ones, mant_o = 0, of_o=1.
REQ-021 sum[W-1]=0, sum nonzero: lz = leading zeros of sum[W-2:0] (bit W-2 set -> 0, bit 0 only set -> W-2); if lz < exp_i: amt_o=lz, mant_o=sum<<lz, exp_o=exp_i-lz.
REQ-022 lz >= exp_i (underflow): amt_o = (exp_i==0) ? 0 : exp_i-1, mant_o = sum<<amt_o, exp_o=0, uf_o=1.
REQ-023 sum all-zero: zero_o=1, amt_o=0, mant_o=0, exp_o=0, other flags 0.
REQ-024 Flags are mutually exclusive except of_o implies rshift_o.
REQ-025 Arithmetic SHALL be unsigned; exponent computations carried at EXP_WIDTH+1 bits before clamping.

Reset
REQ-026 rst=1 at a clock edge SHALL clear both stage valids; out_valid=0, in_ready=1 next cycle; mant_o, exp_o, amt_o and flags = 0.
REQ-027 Reset mid-operation SHALL discard in-flight data; inputs presented while rst=1 are not accepted.

Structure
REQ-028 SIG_WIDTH and EXP_WIDTH defaults SHALL come from the shared parameters include; W and CW derived locally.
REQ-029 One sub-module lzc (parametrised leading-zero counter, width W-1, outputs count and all-zero) SHALL be instantiated in S1.

Verification (SIG_WIDTH=23, W=49, EXP_WIDTH=8)
REQ-030 sum=2^48+3, exp=100 -> 2 cycles later mant=2^47+1, exp=101, amt=1, rshift=1.
REQ-031 sum=2^20, exp=100 -> mant=2^47, exp=73, amt=27; sum=2^47, exp=100 -> amt=0, exp=100.
REQ-032 sum=2^20, exp=10 -> amt=9, mant=2^29, exp=0, uf=1; sum=0 -> zero=1, exp=0.
REQ-033 sum=2^48, exp=254 -> exp=255, mant=0, of=1.
REQ-034 5 back-to-back inputs, out_ready low cycles 2-5 -> in_ready drops after 2 held, outputs stable, all 5 results in order.
REQ-035 rst pulsed with 2 items in flight -> out_valid=0 next cycle, no stale result emitted afterwards.
